// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
//   md_op_e    - MDOp_E encodings (MD_NONE..MD_MFLO); other codes behave as MD_NONE
//   md_state_e - counter/commit FSM states
//   MD_MULT_CYCLES_DEF / MD_DIV_CYCLES_DEF - default busy lengths
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  // True for ops that launch a multi-cycle computation.
  function automatic logic md_is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage connection between the pipeline and the multiply/divide unit.
//   E_V1, E_V2  - forwarded rs/rt operands
//   MDOp_E      - md_op_e code, E_valid - E-stage instruction is real
//   start, busy, md_stall - launch / in-flight / hazard-stall indications
//   E_MDout     - mfhi/mflo read data, HI, LO - architectural registers
// Modports: master = pipeline side, slave = md_unit.
interface md_unit_if;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic [3:0]  MDOp_E;
  logic        E_valid;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] E_MDout;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_V1, E_V2, MDOp_E, E_valid,
    input  start, busy, md_stall, E_MDout, HI, LO
  );

  modport slave (
    input  E_V1, E_V2, MDOp_E, E_valid,
    output start, busy, md_stall, E_MDout, HI, LO
  );
endinterface

// File: rtl/md_unit_core.sv
// md_unit_core: combinational 64-bit result generator for mult/multu/div/divu.
//   i_op          - md_op_e code (non-arith codes give zero results)
//   i_a, i_b      - operands (rs, rt)
//   o_hi, o_lo    - HI/LO result (product high/low, or remainder/quotient)
//   o_div0        - divide op with a zero divisor; results must not be committed
module md_unit_core
  import md_unit_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div0
);

  logic        w_b_zero;
  logic [31:0] w_b_safe;

  // Divisor forced non-zero so the divider never sees /0; the result is discarded anyway.
  assign w_b_zero = (i_b == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : i_b;

  always_comb begin
    o_hi   = 32'd0;
    o_lo   = 32'd0;
    o_div0 = 1'b0;
    case (i_op)
      MD_MULT:  {o_hi, o_lo} = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
      MD_MULTU: {o_hi, o_lo} = {32'd0, i_a} * {32'd0, i_b};
      MD_DIV: begin
        // SV signed divide truncates toward zero; remainder takes the dividend's sign.
        o_lo   = $signed(i_a) / $signed(w_b_safe);
        o_hi   = $signed(i_a) % $signed(w_b_safe);
        o_div0 = w_b_zero;
      end
      MD_DIVU: begin
        o_lo   = i_a / w_b_safe;
        o_hi   = i_a % w_b_safe;
        o_div0 = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning HI/LO.
//   clk   - clock
//   reset - synchronous active-low reset
//   md    - md_unit_if.slave: operands/op/valid in; start, busy, md_stall,
//           E_MDout, HI, LO out
// A start latches the result into pending registers, then the unit stays busy for
// MULT_CYCLES or DIV_CYCLES cycles and commits to HI/LO on the last busy edge.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  md_unit_if.slave md
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e       r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [31:0]     r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic            r_div0;

  logic            w_busy, w_start, w_is_mult, w_commit, w_mthi, w_mtlo;
  logic [31:0]     w_res_hi, w_res_lo;
  logic            w_res_div0;

  md_unit_core u_core (
    .i_op   (md.MDOp_E),
    .i_a    (md.E_V1),
    .i_b    (md.E_V2),
    .o_hi   (w_res_hi),
    .o_lo   (w_res_lo),
    .o_div0 (w_res_div0)
  );

  assign w_busy    = (r_state == StRun);
  assign w_start   = md.E_valid && !w_busy && md_is_arith(md.MDOp_E);
  assign w_is_mult = (md.MDOp_E == MD_MULT) || (md.MDOp_E == MD_MULTU);
  // MT* are blocked while busy, so they can never collide with a commit.
  assign w_mthi    = md.E_valid && !w_busy && (md.MDOp_E == MD_MTHI);
  assign w_mtlo    = md.E_valid && !w_busy && (md.MDOp_E == MD_MTLO);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_commit  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d = StRun;
          w_cnt_d   = w_is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        end
      end
      StRun: begin
        w_cnt_d = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_state_d = StIdle;
          w_commit  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_div0    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_start) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_div0    <= w_res_div0;
      end
      if (w_commit && !r_div0) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_mthi) r_hi <= md.E_V1;
      if (w_mtlo) r_lo <= md.E_V1;
    end
  end

  assign md.start    = w_start;
  assign md.busy     = w_busy;
  assign md.md_stall = w_start || w_busy;
  assign md.HI       = r_hi;
  assign md.LO       = r_lo;
  assign md.E_MDout  = (md.MDOp_E == MD_MFHI) ? r_hi :
                       (md.MDOp_E == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  md_unit_if md ();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered state is observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic valid);
    md.MDOp_E  = op;
    md.E_V1    = a;
    md.E_V2    = b;
    md.E_valid = valid;
    #1;
  endtask

  // n busy cycles; HI/LO must keep their old values until the last edge.
  task automatic busy_run(input string tag, input int n, input logic [31:0] old_hi,
                          input logic [31:0] old_lo);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, md.busy}, 32'd1);
      chk({tag, "_stall"}, {31'd0, md.md_stall}, 32'd1);
      chk({tag, "_hold_hi"}, md.HI, old_hi);
      chk({tag, "_hold_lo"}, md.LO, old_lo);
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    chk("rst_hi", md.HI, 32'd0);
    chk("rst_lo", md.LO, 32'd0);
    chk("rst_busy", {31'd0, md.busy}, 32'd0);
    chk("rst_stall", {31'd0, md.md_stall}, 32'd0);
    reset = 1'b1;
    tick();

    // MFLO straight after reset.
    drive(4'd8, 32'd0, 32'd0, 1'b1);
    chk("mflo_rst", md.E_MDout, 32'd0);

    // E_valid low: no start.
    drive(4'd1, 32'd7, 32'd7, 1'b0);
    chk("inval_start", {31'd0, md.start}, 32'd0);
    tick();
    chk("inval_busy", {31'd0, md.busy}, 32'd0);

    // MULT -2 * 3 = -6.
    drive(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    chk("mult_start", {31'd0, md.start}, 32'd1);
    chk("mult_stall0", {31'd0, md.md_stall}, 32'd1);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    busy_run("mult", 5, 32'd0, 32'd0);
    chk("mult_hi", md.HI, 32'hFFFF_FFFF);
    chk("mult_lo", md.LO, 32'hFFFF_FFFA);
    chk("mult_done", {31'd0, md.busy}, 32'd0);

    // MULTU 0xFFFFFFFF^2.
    drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("multu_stall0", {31'd0, md.md_stall}, 32'd1);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    busy_run("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    chk("multu_hi", md.HI, 32'hFFFF_FFFE);
    chk("multu_lo", md.LO, 32'h0000_0001);
    chk("multu_done", {31'd0, md.md_stall}, 32'd0);

    // DIV -7 / 2 -> q=-3, r=-1.
    drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("div_start", {31'd0, md.start}, 32'd1);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    busy_run("div", 10, 32'hFFFF_FFFE, 32'h0000_0001);
    chk("div_hi", md.HI, 32'hFFFF_FFFF);
    chk("div_lo", md.LO, 32'hFFFF_FFFD);
    chk("div_done", {31'd0, md.busy}, 32'd0);

    // Preload HI=0x11, LO=0x22, then DIVU 7/0 leaves them alone.
    drive(4'd5, 32'h11, 32'd0, 1'b1);
    tick();
    drive(4'd6, 32'h22, 32'd0, 1'b1);
    tick();
    chk("mt_hi", md.HI, 32'h11);
    chk("mt_lo", md.LO, 32'h22);
    drive(4'd4, 32'd7, 32'd0, 1'b1);
    chk("divu0_start", {31'd0, md.start}, 32'd1);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    busy_run("divu0", 10, 32'h11, 32'h22);
    chk("divu0_hi", md.HI, 32'h11);
    chk("divu0_lo", md.LO, 32'h22);
    chk("divu0_done", {31'd0, md.busy}, 32'd0);

    // MTHI then MFHI.
    drive(4'd5, 32'h1234, 32'd0, 1'b1);
    tick();
    drive(4'd7, 32'd0, 32'd0, 1'b1);
    chk("mfhi_hi", md.HI, 32'h1234);
    chk("mfhi_out", md.E_MDout, 32'h1234);
    drive(4'd8, 32'd0, 32'd0, 1'b1);
    chk("mflo_out", md.E_MDout, 32'h22);
    drive(4'd0, 32'd0, 32'd0, 1'b1);
    chk("none_out", md.E_MDout, 32'd0);

    // MULT aborted by reset during busy cycle 3.
    drive(4'd1, 32'd3, 32'd4, 1'b1);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    busy_run("abort", 2, 32'h1234, 32'h22);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_hi", md.HI, 32'd0);
    chk("abort_lo", md.LO, 32'd0);
    chk("abort_busy", {31'd0, md.busy}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("abort_late_lo", md.LO, 32'd0);
    chk("abort_late_busy", {31'd0, md.busy}, 32'd0);

    // MULT 5*6, then a DIV arrives while busy and must be ignored.
    drive(4'd1, 32'd5, 32'd6, 1'b1);
    tick();
    drive(4'd3, 32'd100, 32'd7, 1'b1);
    chk("viol_start", {31'd0, md.start}, 32'd0);
    busy_run("viol", 1, 32'd0, 32'd0);
    drive(4'd7, 32'd0, 32'd0, 1'b1);
    chk("viol_mfhi", md.E_MDout, 32'd0);
    drive(4'd6, 32'hDEAD, 32'd0, 1'b1);
    busy_run("viol_mt", 1, 32'd0, 32'd0);
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    busy_run("viol_tail", 3, 32'd0, 32'd0);
    chk("viol_hi", md.HI, 32'd0);
    chk("viol_lo", md.LO, 32'd30);
    chk("viol_done", {31'd0, md.busy}, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("viol_late_hi", md.HI, 32'd0);
    chk("viol_late_lo", md.LO, 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It sits alongside the ALU and takes the same forwarded E-stage operands.
- Executes mult/multu/div/divu with a fixed multi-cycle latency. Owns the architectural HI/LO registers.
- Serves mfhi/mflo/mthi/mtlo.
- Exports a busy indication that the hazard unit uses to stall the D stage.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start (must be >= 1)
DIV_CYCLES, 10, busy cycles after a div/divu start (must be >= 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
E_V1  input  32  forwarded rs operand (post forwarding mux)
E_V2  input  32  forwarded rt operand (post forwarding mux, pre ALUSrc mux)
MDOp_E  input  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; others treated as NONE
E_valid  input  1  E-stage instruction is real (low for ID_EX bubble/clear)
start  output  1  combinational; high when E_valid and MDOp_E in {1..4} and busy==0
busy  output  1  registered; high while an operation is in flight
md_stall  output  1  combinational start|busy; fed to the hazard unit
E_MDout  output  32  combinational; HI when MFHI, LO when MFLO, else 0
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset (reset==0 at a clk edge):
  - HI=0, LO=0, busy=0, counter=0, pending results=0.
  - A reset mid-operation aborts it; no commit.
- Start cycle (start==1):
  - Operands are latched at the edge.
  - Results are computed into pending_hi/pending_lo.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES; busy goes to 1 at that edge.
- MULT: {pending_hi,pending_lo} = signed(E_V1) * signed(E_V2), full 64 bits.
- MULTU: same product, unsigned.
- DIV: pending_lo = signed quotient, truncated toward zero. pending_hi = signed remainder, which carries the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (E_V2==0 on DIV/DIVU): the op still runs for the full DIV_CYCLES, and HI/LO are left unchanged at commit.
- Counting: while busy, the counter decrements each cycle.
  - At the edge where the counter goes 1->0, HI/LO take the pending values and busy clears.
  - Result: HI/LO are updated exactly N cycles after the start edge, and busy is high for exactly N cycles.
- MTHI/MTLO (E_valid, busy==0): HI<=E_V1 (or LO<=E_V1) at the edge.
- MFHI/MFLO: E_MDout shows the current HI/LO in the same cycle; the value is carried down the pipe like E_AO.
- Ops while busy:
  - An MD-class op (1..8) in E while busy==1 cannot occur under the stall contract. The hazard unit stalls D when D holds an MD-class op and md_stall==1.
  - If such an op occurs anyway, it is ignored: no start, no HI/LO write, E_MDout still reflects HI/LO.
- Simultaneous events:
  - A commit edge and an MTHI/MTLO on the same edge are impossible (busy==1 blocks MT*).
  - start asserts only when busy==0, so back-to-back ops are separated by at least N+1 cycles of E occupancy.
- E_valid==0: no state change, start=0.
- Width rules: all arithmetic is 32x32->64 or 32/32. Unsigned paths zero-extend; signed paths use $signed on both operands.

Decomposition:
- Shared package (md_defs): MDOp encodings (MD_NONE..MD_MFLO) and default cycle counts.
- The hazard unit adds md_stall to its D-stall equation; no change to the forwarding selects.
- Optional sub-module md_core: a combinational 64-bit result generator (op, a, b -> hi, lo, div0). The counter/commit FSM stays in md_unit.
- FSM states: IDLE (busy=0) and RUN (busy=1, counter>0).

Test Plan:
- MULT E_V1=0xFFFFFFFE (-2), E_V2=3 -> busy high 5 cycles; after the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles; md_stall high in the start cycle and all 5 busy cycles.
- DIV -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1) after 10 cycles; DIVU 7/0 with HI=0x11, LO=0x22 preloaded -> both unchanged after 10 cycles.
- MTHI E_V1=0x1234 then MFHI next cycle -> HI=0x1234, E_MDout=0x1234; MFLO after reset -> 0.
- MULT start, then reset=0 on cycle 3 of busy -> next edge HI=LO=0, busy=0, no later commit.
- MULT then DIV issued while busy=1 (stall contract violated) -> DIV ignored; HI/LO hold the MULT result; busy falls after 5 cycles.
